// File: rtl/aha_sif_sram_bridge.sv
// aha_sif_sram_bridge
// SIF slave that turns registered write/read strobes into accesses on a
// single-port, fixed-latency, 64-bit synchronous SRAM. Writes win the port,
// losing reads wait in a small in-order queue, and read data comes back in
// acceptance order as a one-cycle SIF_RD_VALID pulse.
//
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   SIF_WR_*               write strobe, byte address, byte enables, data
//   SIF_RD_EN/ADDR         read request strobe and byte address
//   SIF_RD_DATA/VALID      read return (data held until the next valid)
//   MEM_*                  SRAM port (CE, WE, word address, bit mask, data)
//   RD_OVERFLOW            sticky: a read was dropped on a full queue
module aha_sif_sram_bridge #(
  parameter int ADDR_WIDTH  = 16,
  parameter int RD_LATENCY  = 1,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [31:0]           SIF_WR_ADDR,
  input  logic                  SIF_WR_EN,
  input  logic [7:0]            SIF_WR_STRB,
  input  logic [63:0]           SIF_WR_DATA,
  input  logic [31:0]           SIF_RD_ADDR,
  input  logic                  SIF_RD_EN,
  output logic [63:0]           SIF_RD_DATA,
  output logic                  SIF_RD_VALID,
  output logic                  MEM_CE,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [63:0]           MEM_WMASK,
  output logic [63:0]           MEM_WDATA,
  input  logic [63:0]           MEM_RDATA,
  output logic                  RD_OVERFLOW
);

  localparam int              PTR_W    = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);

  logic [ADDR_WIDTH-1:0] q_mem_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [RD_LATENCY-1:0] tok_q, tok_d;
  logic [63:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [63:0]           last_wdata_q, last_wdata_d;
  logic [63:0]           last_wmask_q, last_wmask_d;

  logic [ADDR_WIDTH-1:0] wr_word, rd_word;
  logic [63:0]           strb_mask;
  logic                  wr_go, ce, we, rd_issue, pop, push, drop;

  // Byte-offset and high address bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{SIF_WR_ADDR, SIF_RD_ADDR};

  assign wr_word = SIF_WR_ADDR[ADDR_WIDTH+2:3];
  assign rd_word = SIF_RD_ADDR[ADDR_WIDTH+2:3];
  assign wr_go   = SIF_WR_EN && (SIF_WR_STRB != '0);

  always_comb begin
    strb_mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      strb_mask[i*8 +: 8] = {8{SIF_WR_STRB[i]}};
    end
  end

  // Port arbitration: write, then queue head, then bypassing read. When the
  // port is idle the address/data/mask outputs replay the last access.
  always_comb begin
    ce           = 1'b0;
    we           = 1'b0;
    rd_issue     = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    last_wmask_d = last_wmask_q;
    if (wr_go) begin
      ce           = 1'b1;
      we           = 1'b1;
      last_addr_d  = wr_word;
      last_wdata_d = SIF_WR_DATA;
      last_wmask_d = strb_mask;
      push         = SIF_RD_EN;
    end else if (count_q != '0) begin
      ce          = 1'b1;
      rd_issue    = 1'b1;
      pop         = 1'b1;
      last_addr_d = q_mem_q[rd_ptr_q];
      push        = SIF_RD_EN;
    end else if (SIF_RD_EN) begin
      ce          = 1'b1;
      rd_issue    = 1'b1;
      last_addr_d = rd_word;
    end
    // A simultaneous pop frees the slot, so a full queue only drops without one.
    drop = push && (count_q == FULL_CNT) && !pop;
  end

  always_comb begin
    q_mem_d  = q_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push && !drop) begin
      q_mem_d[wr_ptr_q] = rd_word;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      count_d           = count_d + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_d - (PTR_W+1)'(1);
    end
    overflow_d = overflow_q | drop;
  end

  // Token delay line: tok_q[RD_LATENCY-1] marks the cycle MEM_RDATA is valid.
  always_comb begin
    tok_d    = '0;
    tok_d[0] = rd_issue;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tok_d[i] = tok_q[i-1];
    end
    rd_valid_d = tok_q[RD_LATENCY-1];
    rd_data_d  = tok_q[RD_LATENCY-1] ? MEM_RDATA : rd_data_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) q_mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      tok_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      last_wmask_q <= '0;
    end else begin
      q_mem_q      <= q_mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      tok_q        <= tok_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      overflow_q   <= overflow_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
      last_wmask_q <= last_wmask_d;
    end
  end

  // Strobes are gated directly by reset so the SRAM sees no access while held.
  assign MEM_CE       = ce & ARESETn;
  assign MEM_WE       = we & ARESETn;
  assign MEM_ADDR     = last_addr_d;
  assign MEM_WDATA    = last_wdata_d;
  assign MEM_WMASK    = last_wmask_d;
  assign SIF_RD_DATA  = rd_data_q;
  assign SIF_RD_VALID = rd_valid_q;
  assign RD_OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_aha_sif_sram_bridge.sv
// Bench for aha_sif_sram_bridge: two instances (RD_LATENCY 1 and 3) share
// the same SIF stimulus, each with its own SRAM model and read scoreboard.
module tb_aha_sif_sram_bridge;

  localparam int L0 = 1;
  localparam int L1 = 3;

  typedef struct { logic [63:0] data; int cyc; } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];

  logic [31:0] wr_addr = '0, rd_addr = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0]  wr_strb = '0;
  logic [63:0] wr_data = '0;

  logic [63:0] o0_rdata, o1_rdata, o0_wmask, o1_wmask, o0_wdata, o1_wdata;
  logic        o0_valid, o1_valid, o0_ce, o1_ce, o0_we, o1_we, o0_ovf, o1_ovf;
  logic [15:0] o0_addr, o1_addr;
  logic [63:0] mrd0, mrd1;
  logic [63:0] mem0 [256];
  logic [63:0] mem1 [256];
  logic [63:0] pipe1 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aha_sif_sram_bridge #(.ADDR_WIDTH(16), .RD_LATENCY(L0), .QUEUE_DEPTH(4)) dut0 (
    .ACLK(clk), .ARESETn(rstn),
    .SIF_WR_ADDR(wr_addr), .SIF_WR_EN(wr_en), .SIF_WR_STRB(wr_strb), .SIF_WR_DATA(wr_data),
    .SIF_RD_ADDR(rd_addr), .SIF_RD_EN(rd_en), .SIF_RD_DATA(o0_rdata), .SIF_RD_VALID(o0_valid),
    .MEM_CE(o0_ce), .MEM_WE(o0_we), .MEM_ADDR(o0_addr), .MEM_WMASK(o0_wmask),
    .MEM_WDATA(o0_wdata), .MEM_RDATA(mrd0), .RD_OVERFLOW(o0_ovf));

  aha_sif_sram_bridge #(.ADDR_WIDTH(16), .RD_LATENCY(L1), .QUEUE_DEPTH(4)) dut1 (
    .ACLK(clk), .ARESETn(rstn),
    .SIF_WR_ADDR(wr_addr), .SIF_WR_EN(wr_en), .SIF_WR_STRB(wr_strb), .SIF_WR_DATA(wr_data),
    .SIF_RD_ADDR(rd_addr), .SIF_RD_EN(rd_en), .SIF_RD_DATA(o1_rdata), .SIF_RD_VALID(o1_valid),
    .MEM_CE(o1_ce), .MEM_WE(o1_we), .MEM_ADDR(o1_addr), .MEM_WMASK(o1_wmask),
    .MEM_WDATA(o1_wdata), .MEM_RDATA(mrd1), .RD_OVERFLOW(o1_ovf));

  // SRAM models: data for an access in cycle T is visible in cycle T+latency;
  // other cycles carry a garbage pattern so mistimed captures show up.
  always @(posedge clk) begin
    mrd0 <= {32'hDEAD_BEEF, 32'(cyc)};
    if (o0_ce) begin
      if (o0_we) mem0[o0_addr[7:0]] <= (mem0[o0_addr[7:0]] & ~o0_wmask) | (o0_wdata & o0_wmask);
      else       mrd0 <= mem0[o0_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    pipe1[0] <= {32'hBAAD_F00D, 32'(cyc)};
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    if (o1_ce) begin
      if (o1_we) mem1[o1_addr[7:0]] <= (mem1[o1_addr[7:0]] & ~o1_wmask) | (o1_wdata & o1_wmask);
      else       pipe1[0] <= mem1[o1_addr[7:0]];
    end
  end
  assign mrd1 = pipe1[2];

  // Scoreboard monitors: pop one expectation per SIF_RD_VALID pulse.
  always @(negedge clk) begin
    if (o0_valid === 1'b1) begin
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_valid: got valid data=%h at cycle %0d, required none", o0_rdata, cyc);
      end else begin
        exp_t e;
        e = sb0.pop_front();
        checks++;
        if (o0_rdata !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL dut0_rd_return: got data=%h cycle=%0d, required data=%h cycle=%0d", o0_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o1_valid === 1'b1) begin
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_valid: got valid data=%h at cycle %0d, required none", o1_rdata, cyc);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        checks++;
        if (o1_rdata !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL dut1_rd_return: got data=%h cycle=%0d, required data=%h cycle=%0d", o1_rdata, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_strb = '0;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [7:0] s, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_strb = s; wr_data = d;
  endtask

  task automatic set_rd(input logic [31:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  // issue < 0: return cycle not checked; otherwise the cycle the SRAM read is issued.
  task automatic push_exp(input logic [63:0] d, input int issue);
    exp_t e0, e1;
    e0.data = d; e0.cyc = (issue < 0) ? -1 : issue + L0 + 1;
    e1.data = d; e1.cyc = (issue < 0) ? -1 : issue + L1 + 1;
    sb0.push_back(e0);
    sb1.push_back(e1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && (sb0.size() != 0 || sb1.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d/%0d reads outstanding, required 0", name, sb0.size(), sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  task automatic test_reset();
    set_wr(32'h40, 8'hFF, 64'h1);
    repeat (3) @(negedge clk);
    checks++;
    if ({o0_ce, o0_we, o1_ce, o1_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mem_strobes: got ce/we %b%b %b%b, required 0000", o0_ce, o0_we, o1_ce, o1_we);
    end
    checks++;
    if (o0_rdata !== 64'h0 || o1_rdata !== 64'h0 || {o0_valid, o1_valid, o0_ovf, o1_ovf} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data %h/%h valid %b%b ovf %b%b, required zeros",
               o0_rdata, o1_rdata, o0_valid, o1_valid, o0_ovf, o1_ovf);
    end
    wr_en = 1'b0; wr_strb = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_write_read();
    next_cycle();
    set_wr(32'h0000_0040, 8'hFF, 64'h1122334455667788);
    @(negedge clk);
    checks++;
    if ({o0_ce, o0_we, o1_ce, o1_we} !== 4'b1111 || o0_addr !== 16'd8 || o1_addr !== 16'd8 ||
        o0_wmask !== '1 || o1_wmask !== '1) begin
      errors++;
      $display("FAIL full_write_access: got ce/we %b%b addr %0d mask %h, required 11 addr 8 mask all-ones",
               o0_ce, o0_we, o0_addr, o0_wmask);
    end
    next_cycle();
    set_rd(32'h40);
    push_exp(64'h1122334455667788, cyc);
    @(negedge clk);
    checks++;
    if ({o0_ce, o0_we, o1_ce, o1_we} !== 4'b1010 || o0_addr !== 16'd8 || o1_addr !== 16'd8) begin
      errors++;
      $display("FAIL bypass_read_access: got ce/we %b%b addr %0d/%0d, required 10 addr 8",
               o0_ce, o0_we, o0_addr, o1_addr);
    end
    next_cycle();
    wait_drain("write_read");
  endtask

  task automatic test_partial_strobe();
    next_cycle();
    set_wr(32'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    @(negedge clk);
    checks++;
    if (o0_wmask !== 64'h00000000FFFFFFFF || o1_wmask !== 64'h00000000FFFFFFFF || o0_we !== 1'b1) begin
      errors++;
      $display("FAIL partial_wmask: got %h/%h we=%b, required 00000000ffffffff we=1", o0_wmask, o1_wmask, o0_we);
    end
    next_cycle();
    set_rd(32'h40);
    push_exp(64'h11223344AAAAAAAA, cyc);
    next_cycle();
    wait_drain("partial_strobe");
  endtask

  task automatic test_same_cycle();
    int c;
    next_cycle();
    set_wr(32'h40, 8'hFF, 64'hCAFEF00DDEADBEEF);
    set_rd(32'h40);
    c = cyc;
    push_exp(64'hCAFEF00DDEADBEEF, c + 1);
    @(negedge clk);
    checks++;
    if ({o0_ce, o0_we, o1_ce, o1_we} !== 4'b1111) begin
      errors++;
      $display("FAIL same_cycle_write_first: got ce/we %b%b %b%b, required 1111", o0_ce, o0_we, o1_ce, o1_we);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({o0_ce, o0_we, o1_ce, o1_we} !== 4'b1010 || o0_addr !== 16'd8 || o1_addr !== 16'd8) begin
      errors++;
      $display("FAIL same_cycle_queue_pop: got ce/we %b%b addr %0d, required 10 addr 8", o0_ce, o0_we, o0_addr);
    end
    wait_drain("same_cycle");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      set_wr(32'h100 + 32'(i * 8), 8'hFF, {8{8'(i + 1)}});
    end
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      set_wr(32'h180 + 32'(i * 8), 8'hFF, 64'hFFFF0000 ^ 64'(i));
      set_rd(32'h100 + 32'(i * 8));
      if (i < 4) push_exp({8{8'(i + 1)}}, -1);
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (o0_ovf !== 1'b0 || o1_ovf !== 1'b0) begin
          errors++;
          $display("FAIL overflow_early: got %b/%b with queue just full, required 0", o0_ovf, o1_ovf);
        end
      end
      if (i == 5) begin
        checks++;
        if (o0_ovf !== 1'b1 || o1_ovf !== 1'b1) begin
          errors++;
          $display("FAIL overflow_set: got %b/%b, required 1", o0_ovf, o1_ovf);
        end
      end
    end
    next_cycle();
    wait_drain("overflow");
    repeat (3) @(negedge clk);
    checks++;
    if (o0_ovf !== 1'b1 || o1_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b/%b, required 1", o0_ovf, o1_ovf);
    end
    checks++;
    if (o0_rdata !== 64'h0404040404040404 || o1_rdata !== 64'h0404040404040404) begin
      errors++;
      $display("FAIL rd_data_hold: got %h/%h, required 0404040404040404", o0_rdata, o1_rdata);
    end
    next_cycle();
    set_wr(32'h40, 8'h00, 64'h0);
    @(negedge clk);
    checks++;
    if (o0_ce !== 1'b0 || o1_ce !== 1'b0 || o0_addr !== 16'd35 || o1_addr !== 16'd35 ||
        o0_wdata !== 64'hFFFF0005 || o1_wdata !== 64'hFFFF0005) begin
      errors++;
      $display("FAIL zero_strobe_noop: got ce %b/%b addr %0d/%0d wdata %h, required ce 0 addr 35 wdata ffff0005",
               o0_ce, o1_ce, o0_addr, o1_addr, o0_wdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_wr(32'h200 + 32'(i * 8), 8'hFF, 64'h5555_0000 + 64'(i));
      set_rd(32'h40);
    end
    next_cycle();
    next_cycle();
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (o0_rdata !== 64'h0 || o1_rdata !== 64'h0 || {o0_valid, o1_valid, o0_ovf, o1_ovf, o0_ce, o1_ce} !== 6'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got data %h/%h valid %b%b ovf %b%b ce %b%b, required zeros",
               o0_rdata, o1_rdata, o0_valid, o1_valid, o0_ovf, o1_ovf, o0_ce, o1_ce);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({o0_valid, o1_valid, o0_ovf, o1_ovf} !== 4'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: got valid %b%b ovf %b%b, required 0000", o0_valid, o1_valid, o0_ovf, o1_ovf);
      end
    end
    next_cycle();
    set_rd(32'h40);
    push_exp(64'hCAFEF00DDEADBEEF, cyc);
    next_cycle();
    wait_drain("reset_midop");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      set_wr(32'h200 + 32'(i * 8), 8'hFF, 64'h0123456789ABCDE0 + 64'(i));
    end
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      set_rd(32'h200 + 32'(i * 8));
      push_exp(64'h0123456789ABCDE0 + 64'(i), cyc);
      @(negedge clk);
      checks++;
      if (o0_ce !== 1'b1 || o1_ce !== 1'b1 || o0_addr !== 16'(64 + i) || o1_addr !== 16'(64 + i)) begin
        errors++;
        $display("FAIL b2b_read_issue: got ce %b/%b addr %0d/%0d, required 1 addr %0d",
                 o0_ce, o1_ce, o0_addr, o1_addr, 64 + i);
      end
    end
    next_cycle();
    wait_drain("back_to_back");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_same_cycle();
    test_overflow();
    test_reset_midop();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
